noc_phase_sequencer: RTL and testbench
======================================

NOC_PHASE_SEQUENCER -- requirements
Module: noc_phase_sequencer

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- NUM_ROUTERS, 16, routers in the mesh; also the number of routing-table destinations.
- DST_BITS, 4, width of the destination index; 2**DST_BITS >= NUM_ROUTERS.
- CYCLE_BITS, 16, width of the simulated-cycle counter.
- FILL_BITS, 8, width of the traffic-entry index.
REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, level; begins a run when sampled high in IDLE.
- abort, in, 1, forces a return to IDLE from any state.
- max_cycle, in, CYCLE_BITS, number of simulated cycles to run; sampled in IDLE on start.
- fill_count, in, FILL_BITS, highest per-source traffic entry count; sampled in IDLE on start.
- all_done, in, 1, AND of every router done flag.
- router_op, out, 4, broadcast router operation code.
- traffic_op, out, 4, broadcast traffic-queue operation code.
- rt_dst, out, DST_BITS, destination index of the current routing-table load.
- fill_idx, out, FILL_BITS, traffic entry index of the current fill.
- in_cycle, out, CYCLE_BITS, count of completed simulated cycles.
- busy, out, 1, high in every state except IDLE and DONE.
- finished, out, 1, high in DONE only.

Function
REQ-003 SHALL use these op encodings on router_op and traffic_op: NOP=0, Init=1, LoadRt=2, LoadStaging=3, Phase0=4, Phase1=5, Fill=7.
REQ-004 SHALL implement the FSM states IDLE, INIT, LOAD_RT, INIT_TRAFFIC, FILL, LOAD_STAGING, PHASE0, PHASE1 and DONE.
REQ-005 SHALL register all outputs; each output reflects the state entered on the same clock edge.
REQ-006 IDLE: router_op=NOP and traffic_op=NOP; on start=1, latch max_cycle and fill_count and go to INIT.
REQ-007 INIT: router_op=Init for exactly 1 cycle, then go to LOAD_RT with rt_dst=0.
REQ-008 LOAD_RT: router_op=LoadRt; rt_dst increments by 1 each cycle; after rt_dst=NUM_ROUTERS-1, go to INIT_TRAFFIC; this state lasts exactly NUM_ROUTERS cycles.
REQ-009 INIT_TRAFFIC: traffic_op=Init and router_op=NOP for 1 cycle, then go to FILL with fill_idx=0; if the latched fill_count is 0, go directly to LOAD_STAGING instead.
REQ-010 FILL: traffic_op=Fill; fill_idx increments by 1 each cycle; after fill_idx=fill_count-1, go to LOAD_STAGING.
REQ-011 Cycle loop: LOAD_STAGING (router_op=3) -> PHASE0 (router_op=4) -> PHASE1 (router_op=5), one cycle each; each simulated cycle costs 3 clocks.
REQ-012 On leaving PHASE1, in_cycle SHALL increment by 1.
REQ-013 Exit test, evaluated in PHASE1: if in_cycle+1 == latched max_cycle, or all_done=1, go to DONE; otherwise go to LOAD_STAGING.
REQ-014 If max_cycle=0 is latched, the run SHALL go INIT_TRAFFIC/FILL -> DONE with no cycle loop, and in_cycle stays 0.
REQ-015 DONE: router_op=NOP, traffic_op=NOP, finished=1, in_cycle held; go to IDLE when start=0.
REQ-016 abort=1 SHALL go to IDLE on the next edge from any state and override all other transitions; counters are not cleared by abort.
REQ-017 On entry to INIT, in_cycle, rt_dst and fill_idx SHALL clear to 0.
REQ-018 in_cycle SHALL saturate at all-ones and never wrap.
REQ-019 all_done SHALL be ignored in every state other than PHASE1.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=IDLE, router_op=0, traffic_op=0, rt_dst=0, fill_idx=0, in_cycle=0, busy=0, finished=0.
REQ-021 Reset asserted mid-run SHALL discard the run; after release the block waits in IDLE for a fresh start.
REQ-022 Reset release SHALL be recognised on the first clk edge with rst_n=1.

Verification
REQ-023 NUM_ROUTERS=4, start with max_cycle=2 and fill_count=3 -> router_op sequence 1,2,2,2,2,0,0,0,0,3,4,5,3,4,5,0; rt_dst steps 0..3; fill_idx steps 0..2; finished=1 with in_cycle=2.
REQ-024 fill_count=0 -> INIT_TRAFFIC is followed directly by LOAD_STAGING and traffic_op never equals 7.
REQ-025 all_done=1 asserted during the second PHASE0 -> DONE follows the second PHASE1, in_cycle=2, even with max_cycle=100.
REQ-026 abort pulsed during LOAD_RT at rt_dst=2 -> IDLE next edge, busy=0; a new start restarts with rt_dst=0.
REQ-027 rst_n low asynchronously during PHASE1 -> all outputs zero before the next edge; in_cycle=0.
REQ-028 CYCLE_BITS=2, max_cycle=0 -> DONE with no LOAD_STAGING ever issued.

Source files
------------

// File: rtl/noc_phase_sequencer.sv
`timescale 1ns/1ps
// Broadcast phase sequencer for the NoC mesh model: init, routing-table load,
// traffic fill, then a three-clock LOAD_STAGING/PHASE0/PHASE1 loop per simulated cycle.
module noc_phase_sequencer #(
  parameter int NUM_ROUTERS = 16,
  parameter int DST_BITS    = 4,
  parameter int CYCLE_BITS  = 16,
  parameter int FILL_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CYCLE_BITS-1:0] max_cycle,
  input  logic [FILL_BITS-1:0]  fill_count,
  input  logic                  all_done,
  output logic [3:0]            router_op,
  output logic [3:0]            traffic_op,
  output logic [DST_BITS-1:0]   rt_dst,
  output logic [FILL_BITS-1:0]  fill_idx,
  output logic [CYCLE_BITS-1:0] in_cycle,
  output logic                  busy,
  output logic                  finished
);

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_INIT     = 4'd1;
  localparam logic [3:0] OP_LOAD_RT  = 4'd2;
  localparam logic [3:0] OP_LOAD_STG = 4'd3;
  localparam logic [3:0] OP_PHASE0   = 4'd4;
  localparam logic [3:0] OP_PHASE1   = 4'd5;
  localparam logic [3:0] OP_FILL     = 4'd7;

  localparam int FW = FILL_BITS + 1;
  localparam int CW = CYCLE_BITS + 1;
  localparam logic [DST_BITS-1:0] LAST_DST = DST_BITS'(NUM_ROUTERS - 1);

  typedef enum logic [3:0] {
    IDLE, INIT, LOAD_RT, INIT_TRAFFIC, FILL, LOAD_STAGING, PHASE0, PHASE1, DONE
  } state_t;

  state_t                state;
  logic [CYCLE_BITS-1:0] max_q;
  logic [FILL_BITS-1:0]  fill_q;
  logic                  fill_last;
  logic                  cycle_last;

  // Widened compares so the "minus one" boundaries never wrap.
  assign fill_last  = (FW'(fill_idx) + FW'(1)) == FW'(fill_q);
  assign cycle_last = (CW'(in_cycle) + CW'(1)) == CW'(max_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      max_q      <= '0;
      fill_q     <= '0;
      router_op  <= OP_NOP;
      traffic_op <= OP_NOP;
      rt_dst     <= '0;
      fill_idx   <= '0;
      in_cycle   <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      router_op  <= OP_NOP;
      traffic_op <= OP_NOP;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          router_op  <= OP_NOP;
          traffic_op <= OP_NOP;
          if (start) begin
            state     <= INIT;
            max_q     <= max_cycle;
            fill_q    <= fill_count;
            router_op <= OP_INIT;
            rt_dst    <= '0;
            fill_idx  <= '0;
            in_cycle  <= '0;
            busy      <= 1'b1;
            finished  <= 1'b0;
          end
        end
        INIT: begin
          state     <= LOAD_RT;
          router_op <= OP_LOAD_RT;
          rt_dst    <= '0;
        end
        LOAD_RT: begin
          if (rt_dst == LAST_DST) begin
            state      <= INIT_TRAFFIC;
            router_op  <= OP_NOP;
            traffic_op <= OP_INIT;
          end else begin
            rt_dst <= rt_dst + DST_BITS'(1);
          end
        end
        // Both traffic states share the exit into either the cycle loop or DONE.
        INIT_TRAFFIC, FILL: begin
          traffic_op <= OP_NOP;
          if (state == INIT_TRAFFIC && fill_q != '0) begin
            state      <= FILL;
            traffic_op <= OP_FILL;
            fill_idx   <= '0;
          end else if (state == FILL && !fill_last) begin
            traffic_op <= OP_FILL;
            fill_idx   <= fill_idx + FILL_BITS'(1);
          end else if (max_q == '0) begin
            state     <= DONE;
            router_op <= OP_NOP;
            busy      <= 1'b0;
            finished  <= 1'b1;
          end else begin
            state     <= LOAD_STAGING;
            router_op <= OP_LOAD_STG;
          end
        end
        LOAD_STAGING: begin
          state     <= PHASE0;
          router_op <= OP_PHASE0;
        end
        PHASE0: begin
          state     <= PHASE1;
          router_op <= OP_PHASE1;
        end
        PHASE1: begin
          if (in_cycle != '1) in_cycle <= in_cycle + CYCLE_BITS'(1);
          if (cycle_last || all_done) begin
            state     <= DONE;
            router_op <= OP_NOP;
            busy      <= 1'b0;
            finished  <= 1'b1;
          end else begin
            state     <= LOAD_STAGING;
            router_op <= OP_LOAD_STG;
          end
        end
        DONE: begin
          router_op  <= OP_NOP;
          traffic_op <= OP_NOP;
          if (!start) begin
            state    <= IDLE;
            finished <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          router_op  <= OP_NOP;
          traffic_op <= OP_NOP;
          busy       <= 1'b0;
          finished   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_phase_sequencer.sv
`timescale 1ns/1ps
// Randomized bench for noc_phase_sequencer: each run's expected per-clock outputs
// are built as a list straight from the phase rules, then compared step by step.
module tb_noc_phase_sequencer;

  localparam int NR = 4;
  localparam int DB = 2;
  localparam int CB = 8;
  localparam int FB = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CB-1:0] max_cycle;
  logic [FB-1:0] fill_count;
  logic          all_done;
  logic [3:0]    router_op;
  logic [3:0]    traffic_op;
  logic [DB-1:0] rt_dst;
  logic [FB-1:0] fill_idx;
  logic [CB-1:0] in_cycle;
  logic          busy;
  logic          finished;

  noc_phase_sequencer #(
    .NUM_ROUTERS(NR), .DST_BITS(DB), .CYCLE_BITS(CB), .FILL_BITS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .max_cycle(max_cycle), .fill_count(fill_count), .all_done(all_done),
    .router_op(router_op), .traffic_op(traffic_op), .rt_dst(rt_dst),
    .fill_idx(fill_idx), .in_cycle(in_cycle), .busy(busy), .finished(finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int rop; int top; int bsy; int fin; int cyc; int rt; int fi; int p1cyc;
  } exp_t;

  exp_t q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void addEntry(int rop, int top, int bsy, int fin, int cyc, int rt, int fi, int p1cyc);
    exp_t e;
    e.rop = rop; e.top = top; e.bsy = bsy; e.fin = fin;
    e.cyc = cyc; e.rt = rt; e.fi = fi; e.p1cyc = p1cyc;
    q.push_back(e);
  endfunction

  // One entry per clock after the start edge; rt/fi of -1 mean "not meaningful here".
  function automatic void buildExpected(int mx, int fl, int da);
    int k;
    q.delete();
    addEntry(1, 0, 1, 0, 0, -1, -1, 0);
    for (int r = 0; r < NR; r++) addEntry(2, 0, 1, 0, 0, r, -1, 0);
    addEntry(0, 1, 1, 0, 0, -1, -1, 0);
    for (int f = 0; f < fl; f++) addEntry(0, 7, 1, 0, 0, -1, f, 0);
    if (mx == 0) k = 0;
    else if (da != 0 && da < mx) k = da;
    else k = mx;
    for (int j = 1; j <= k; j++) begin
      addEntry(3, 0, 1, 0, j - 1, -1, -1, 0);
      addEntry(4, 0, 1, 0, j - 1, -1, -1, 0);
      addEntry(5, 0, 1, 0, j - 1, -1, -1, j);
    end
    addEntry(0, 0, 0, 1, k, -1, -1, 0);
  endfunction

  task automatic checkEntry(input int i);
    string s;
    s = $sformatf("step%0d", i);
    checkOutput({s, " router_op"}, 32'(router_op), q[i].rop);
    checkOutput({s, " traffic_op"}, 32'(traffic_op), q[i].top);
    checkOutput({s, " busy"}, 32'(busy), q[i].bsy);
    checkOutput({s, " finished"}, 32'(finished), q[i].fin);
    checkOutput({s, " in_cycle"}, 32'(in_cycle), q[i].cyc);
    if (q[i].rt >= 0) checkOutput({s, " rt_dst"}, 32'(rt_dst), q[i].rt);
    if (q[i].fi >= 0) checkOutput({s, " fill_idx"}, 32'(fill_idx), q[i].fi);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " router_op"}, 32'(router_op), 0);
    checkOutput({tag, " traffic_op"}, 32'(traffic_op), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " finished"}, 32'(finished), 0);
  endtask

  // abort_at / reset_at interrupt the run right after that step is checked (-1 = never).
  task automatic applyStimulus(input int mx, input int fl, input int da,
                               input int abort_at, input int reset_at);
    buildExpected(mx, fl, da);
    @(negedge clk);
    start      = 1'b1;
    max_cycle  = CB'(mx);
    fill_count = FB'(fl);
    all_done   = 1'($urandom_range(0, 1));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      checkEntry(i);
      if (i == abort_at) begin
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checkIdle("abort");
        checkOutput("abort rt_dst held", 32'(rt_dst), q[i].rt);
        checkOutput("abort in_cycle held", 32'(in_cycle), q[i].cyc);
        return;
      end
      if (i == reset_at) begin
        #1 rst_n = 1'b0;
        #1;
        checkIdle("async reset");
        checkOutput("async reset rt_dst", 32'(rt_dst), 0);
        checkOutput("async reset fill_idx", 32'(fill_idx), 0);
        checkOutput("async reset in_cycle", 32'(in_cycle), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle("post reset");
        return;
      end
      start    = 1'($urandom_range(0, 1));
      all_done = (q[i].p1cyc != 0) ? (q[i].p1cyc == da) : 1'($urandom_range(0, 1));
    end
    start = 1'b1;
    @(negedge clk);
    checkOutput("done hold finished", 32'(finished), 1);
    checkOutput("done hold in_cycle", 32'(in_cycle), q[q.size()-1].cyc);
    checkOutput("done hold router_op", 32'(router_op), 0);
    start = 1'b0;
    @(negedge clk);
    checkIdle("back to idle");
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    max_cycle  = '0;
    fill_count = '0;
    all_done   = 1'b0;
    #12;
    checkIdle("reset");
    checkOutput("reset rt_dst", 32'(rt_dst), 0);
    checkOutput("reset fill_idx", 32'(fill_idx), 0);
    checkOutput("reset in_cycle", 32'(in_cycle), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("idle after reset");

    applyStimulus(2, 3, 0, -1, -1);
    applyStimulus(3, 0, 0, -1, -1);
    applyStimulus(100, 2, 2, -1, -1);
    applyStimulus(3, 1, 0, 3, -1);
    applyStimulus(2, 3, 0, -1, -1);
    applyStimulus(0, 2, 0, -1, -1);
    applyStimulus(0, 0, 0, -1, -1);
    applyStimulus(3, 1, 0, -1, 9);
    applyStimulus(1, 1, 0, -1, -1);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 7)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
